// File: rtl/fifo_arb_pkg.sv
// Shared encodings and width helpers for the FIFO write arbiter and a future read-side scheduler.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bcnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from last_id+1 (mod NUM_REQ).
// Zero latency, no flow control; pick is all-zero when no req bit is set.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    pick_id
);

  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  // Lower copy is masked up to last_id, so the upper copy provides the wrap-around.
  always_comb begin
    masked = {req, req};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i <= int'(last_id)) masked[i] = 1'b0;
    end
    found   = 1'b0;
    pick_id = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        found   = 1'b1;
        pick_id = ID_W'(i % NUM_REQ);
      end
    end
    pick = '0;
    if (found) pick[pick_id] = 1'b1;
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter in front of one sync_fifo write port; 1 output register stage (grant->beat 2 cycles).
// Backpressure: fifo_wr_ready_i low with the output reg full drops the granted req_ready_o in the same cycle.
module sync_fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int ID_W       = id_width(NUM_REQ),
  parameter int BCNT_W     = bcnt_width(MAX_BURST)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [ID_W-1:0]               fifo_id_o,
  output logic                          fifo_wr_valid_o,
  input  logic                          fifo_wr_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  arb_state_t            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_d;
  logic [ID_W-1:0]       last_id_q, last_id_d;
  logic [BCNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]    pick;
  logic [ID_W-1:0]       pick_id;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  out_free;
  logic                  beat_hs;
  logic                  burst_end;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req_valid_i),
    .last_id (last_id_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  // grant_o is one-hot in BURST and zero in IDLE, so the mux yields nothing while idle.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_o[i]) begin
        sel_data  = req_data_i[DATA_WIDTH*i +: DATA_WIDTH];
        sel_valid = req_valid_i[i];
        sel_last  = req_last_i[i];
      end
    end
  end

  assign busy_o      = (state_q == ARB_BURST);
  assign out_free    = ~fifo_wr_valid_o | fifo_wr_ready_i;
  assign req_ready_o = (busy_o && out_free) ? grant_o : '0;
  assign beat_hs     = busy_o & sel_valid & out_free;
  assign burst_end   = sel_last | (beat_cnt_q == BCNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_o;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (|req_valid_i) begin
          grant_d    = pick;
          last_id_d  = pick_id;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // The grant stays locked until a handshake ends the burst, however long valid stays low.
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (burst_end) begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_o    <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_o    <= grant_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // In BURST last_id_q is the granted index, so it doubles as the source ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_valid_o <= 1'b0;
      fifo_data_o     <= '0;
      fifo_id_o       <= '0;
    end else if (beat_hs) begin
      fifo_wr_valid_o <= 1'b1;
      fifo_data_o     <= sel_data;
      fifo_id_o       <= last_id_q;
    end else if (fifo_wr_ready_i) begin
      fifo_wr_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: queued producers, scoreboard of expected FIFO writes, directed timing checks.
module tb_sync_fifo_wr_arb;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_last;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      fifo_data;
  logic [IDW-1:0]     fifo_id;
  logic               fifo_wr_valid;
  logic               fifo_wr_ready;
  logic [NR-1:0]      grant;
  logic               busy;

  typedef struct packed {logic last; logic [DW-1:0] data;} beat_t;
  typedef struct packed {logic [IDW-1:0] id; logic [DW-1:0] data;} exp_t;

  beat_t         pq[NR][$];
  exp_t          sb[$];
  logic [NR-1:0] en;
  int            vectors = 0;
  int            miscompares = 0;
  logic [3:0]    gexp [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

  always #5 clk = ~clk;

  sync_fifo_wr_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_data_i      (req_data),
    .req_valid_i     (req_valid),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .fifo_data_o     (fifo_data),
    .fifo_id_o       (fifo_id),
    .fifo_wr_valid_o (fifo_wr_valid),
    .fifo_wr_ready_i (fifo_wr_ready),
    .grant_o         (grant),
    .busy_o          (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int p, input int n, input logic [DW-1:0] base, input bit with_last);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = base + DW'(k);
      b.last = with_last && (k == n - 1);
      pq[p].push_back(b);
    end
  endtask

  task automatic expect_beat(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = IDW'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  function automatic bit producers_busy();
    for (int i = 0; i < NR; i++) if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) pq[i].delete();
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    clear_queues();
    en = '1;
    fifo_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || producers_busy()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'(0));
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_grant"}, 64'(grant), 64'(0));
    check_eq({pfx, "_ready"}, 64'(req_ready), 64'(0));
    check_eq({pfx, "_wr_valid"}, 64'(fifo_wr_valid), 64'(0));
    check_eq({pfx, "_data"}, 64'(fifo_data), 64'(0));
    check_eq({pfx, "_id"}, 64'(fifo_id), 64'(0));
    check_eq({pfx, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Producer model: pops a beat after a handshake seen mid-cycle, then presents the next one.
  initial begin : driver
    logic [NR-1:0] hs;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (en[i] && pq[i].size() > 0) begin
          req_valid[i]             = 1'b1;
          req_last[i]              = pq[i][0].last;
          req_data[DW*i +: DW]     = pq[i][0].data;
        end else begin
          req_valid[i]             = 1'b0;
          req_last[i]              = 1'b0;
          req_data[DW*i +: DW]     = '0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_eq("ready_only_granted", 64'(req_ready & ~grant), 64'(0));
        if (fifo_wr_valid && fifo_wr_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_beat", 64'(fifo_data), 64'(0));
          end else begin
            e = sb.pop_front();
            check_eq("beat_id", 64'(fifo_id), 64'(e.id));
            check_eq("beat_data", 64'(fifo_data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst           = 1'b1;
    en            = '1;
    fifo_wr_ready = 1'b1;
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single burst from producer 2
    @(negedge clk);
    send(2, 3, 32'hA0, 1'b1);
    for (int k = 0; k < 3; k++) expect_beat(2, 32'hA0 + DW'(k));
    @(negedge clk);
    check_eq("single_c0_grant", 64'(grant), 64'(0));
    check_eq("single_c0_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check_eq("single_c1_grant", 64'(grant), 64'(4'b0100));
    check_eq("single_c1_busy", 64'(busy), 64'(1));
    check_eq("single_c1_ready", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    check_eq("single_c2_wr_valid", 64'(fifo_wr_valid), 64'(1));
    check_eq("single_c2_data", 64'(fifo_data), 64'(32'hA0));
    @(negedge clk);
    @(negedge clk);
    check_eq("single_c4_data", 64'(fifo_data), 64'(32'hA2));
    check_eq("single_c4_id", 64'(fifo_id), 64'(2));
    @(negedge clk);
    check_eq("single_c5_busy", 64'(busy), 64'(0));
    check_eq("single_c5_grant", 64'(grant), 64'(0));
    check_eq("single_c5_wr_valid", 64'(fifo_wr_valid), 64'(0));
    wait_drain("single_drain", 200);

    // Rotation fairness with 1-beat bursts
    do_reset();
    @(negedge clk);
    send(0, 1, 32'hB0, 1'b1);
    send(0, 1, 32'hB1, 1'b1);
    send(1, 1, 32'hC1, 1'b1);
    send(2, 1, 32'hC2, 1'b1);
    send(3, 1, 32'hC3, 1'b1);
    expect_beat(0, 32'hB0);
    expect_beat(1, 32'hC1);
    expect_beat(2, 32'hC2);
    expect_beat(3, 32'hC3);
    expect_beat(0, 32'hB1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("rr_grant_c%0d", k), 64'(grant), 64'(gexp[k]));
    end
    wait_drain("rr_drain", 200);

    // Forced rotation after MAX_BURST beats
    do_reset();
    @(negedge clk);
    send(0, 10, 32'hD0, 1'b0);
    send(1, 2, 32'hE0, 1'b1);
    for (int k = 0; k < 4; k++) expect_beat(0, 32'hD0 + DW'(k));
    for (int k = 0; k < 2; k++) expect_beat(1, 32'hE0 + DW'(k));
    for (int k = 4; k < 10; k++) expect_beat(0, 32'hD0 + DW'(k));
    wait_drain("forced_drain", 300);
    repeat (2) @(negedge clk);
    check_eq("forced_locked_grant", 64'(grant), 64'(4'b0001));
    check_eq("forced_locked_busy", 64'(busy), 64'(1));

    // Backpressure mid-burst
    do_reset();
    @(negedge clk);
    send(3, 6, 32'hF0, 1'b1);
    for (int k = 0; k < 6; k++) expect_beat(3, 32'hF0 + DW'(k));
    repeat (4) @(posedge clk);
    #1 fifo_wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("bp_hold_data_%0d", k), 64'(fifo_data), 64'(32'hF1));
      check_eq($sformatf("bp_hold_valid_%0d", k), 64'(fifo_wr_valid), 64'(1));
      check_eq($sformatf("bp_ready_%0d", k), 64'(req_ready), 64'(0));
      check_eq($sformatf("bp_grant_%0d", k), 64'(grant), 64'(4'b1000));
    end
    @(posedge clk);
    #1 fifo_wr_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_c8_busy", 64'(busy), 64'(1));
    @(negedge clk);
    check_eq("bp_c9_busy", 64'(busy), 64'(1));
    @(negedge clk);
    check_eq("bp_c10_rotate", 64'(busy), 64'(0));
    wait_drain("bp_drain", 200);

    // Locked grant while the granted producer stalls
    do_reset();
    @(negedge clk);
    send(0, 3, 32'h60, 1'b1);
    send(1, 1, 32'h71, 1'b1);
    send(2, 1, 32'h72, 1'b1);
    for (int k = 0; k < 3; k++) expect_beat(0, 32'h60 + DW'(k));
    expect_beat(1, 32'h71);
    expect_beat(2, 32'h72);
    @(negedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("lock_grant_%0d", k), 64'(grant), 64'(4'b0001));
      check_eq($sformatf("lock_others_ready_%0d", k), 64'(req_ready & 4'b1110), 64'(0));
      check_eq($sformatf("lock_busy_%0d", k), 64'(busy), 64'(1));
    end
    en[0] = 1'b1;
    wait_drain("lock_drain", 200);

    // Asynchronous reset mid-burst
    do_reset();
    @(negedge clk);
    send(0, 4, 32'h90, 1'b0);
    expect_beat(0, 32'h90);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    clear_queues();
    #1;
    check_outputs_zero("arst");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send(1, 1, 32'h81, 1'b1);
    send(0, 1, 32'h80, 1'b1);
    expect_beat(0, 32'h80);
    expect_beat(1, 32'h81);
    @(negedge clk);
    @(negedge clk);
    check_eq("arst_first_grant", 64'(grant), 64'(4'b0001));
    wait_drain("arst_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
